// File: rtl/wb_timeout_guard.sv
// ============================================================================
// Module      : wb_timeout_guard
// Description : Wishbone pipelined pass-through guard that aborts a stalled
//               bus cycle with err and releases the downstream arbiter port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timeout_guard #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH/8,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES+1)
) (
    input  logic                    clk,
    input  logic                    rst,

    // upstream master side
    input  logic [ADDR_WIDTH-1:0]   wbm_adr,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_m,
    output logic [DATA_WIDTH-1:0]   wbm_dat_s,
    input  logic [SELECT_WIDTH-1:0] wbm_sel,
    input  logic                    wbm_we,
    input  logic                    wbm_cyc,
    input  logic                    wbm_stb,
    output logic                    wbm_ack,
    output logic                    wbm_err,
    output logic                    wbm_stall,

    // downstream side toward the data bus arbiter
    output logic [ADDR_WIDTH-1:0]   wbs_adr,
    output logic [DATA_WIDTH-1:0]   wbs_dat_m,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_s,
    output logic [SELECT_WIDTH-1:0] wbs_sel,
    output logic                    wbs_we,
    output logic                    wbs_cyc,
    output logic                    wbs_stb,
    input  logic                    wbs_ack,
    input  logic                    wbs_err,
    input  logic                    wbs_stall,

    input  logic                    clear_status,
    output logic                    timeout_flag,
    output logic [ADDR_WIDTH-1:0]   timeout_addr
);

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_ABORT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_last_adr;
    logic                  r_timeout_flag;
    logic [ADDR_WIDTH-1:0] r_timeout_addr;
    logic                  w_resp;
    logic                  w_expired;
    logic                  w_accept;

    assign w_resp    = wbs_ack | wbs_err;
    assign w_expired = (r_cnt == C_TIMEOUT) && !w_resp && wbm_cyc;
    assign w_accept  = (r_state == ST_PASS) && wbm_cyc && wbm_stb && !wbs_stall;

    // Request payload and read data never need gating.
    assign wbs_adr   = wbm_adr;
    assign wbs_dat_m = wbm_dat_m;
    assign wbs_sel   = wbm_sel;
    assign wbs_we    = wbm_we;
    assign wbm_dat_s = wbs_dat_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_PASS;
            r_cnt          <= '0;
            r_last_adr     <= '0;
            r_timeout_flag <= 1'b0;
            r_timeout_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_last_adr <= wbm_adr;
            end
            // An abort in the same cycle as a clear keeps the flag set.
            if (r_state == ST_ABORT) begin
                r_timeout_flag <= 1'b1;
                r_timeout_addr <= r_last_adr;
            end else if (clear_status) begin
                r_timeout_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        w_cnt_next = '0;
        if ((r_state == ST_PASS) && wbm_cyc && !w_resp) begin
            w_cnt_next = (r_cnt == C_TIMEOUT) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        wbs_cyc      = wbm_cyc;
        wbs_stb      = wbm_stb;
        wbm_ack      = wbs_ack;
        wbm_err      = wbs_err;
        wbm_stall    = wbs_stall;
        if (rst) begin
            // Outputs stay transparent in reset, except that no err is reported.
            wbm_err = 1'b0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (w_expired) begin
                        w_state_next = ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    wbs_cyc      = 1'b0;
                    wbs_stb      = 1'b0;
                    wbm_ack      = 1'b0;
                    wbm_err      = 1'b1;
                    wbm_stall    = 1'b1;
                    w_state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Late slave responses are swallowed until the master ends its cycle.
                    wbs_cyc   = 1'b0;
                    wbs_stb   = 1'b0;
                    wbm_ack   = 1'b0;
                    wbm_err   = 1'b0;
                    wbm_stall = 1'b1;
                    if (!wbm_cyc) begin
                        w_state_next = ST_PASS;
                    end
                end
                default: begin
                    w_state_next = ST_PASS;
                end
            endcase
        end
    end

    assign timeout_flag = r_timeout_flag;
    assign timeout_addr = r_timeout_addr;

endmodule

`default_nettype wire

// File: tb/tb_wb_timeout_guard.sv
// ============================================================================
// Module      : tb_wb_timeout_guard
// Description : Directed self-checking bench for wb_timeout_guard (timeout 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_timeout_guard;

    localparam int C_DW = 32;
    localparam int C_AW = 32;
    localparam int C_SW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [C_AW-1:0] wbm_adr;
    logic [C_DW-1:0] wbm_dat_m;
    logic [C_DW-1:0] wbm_dat_s;
    logic [C_SW-1:0] wbm_sel;
    logic            wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err, wbm_stall;
    logic [C_AW-1:0] wbs_adr;
    logic [C_DW-1:0] wbs_dat_m;
    logic [C_DW-1:0] wbs_dat_s;
    logic [C_SW-1:0] wbs_sel;
    logic            wbs_we, wbs_cyc, wbs_stb, wbs_ack, wbs_err, wbs_stall;
    logic            clear_status;
    logic            timeout_flag;
    logic [C_AW-1:0] timeout_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_timeout_guard #(
        .DATA_WIDTH     (C_DW),
        .ADDR_WIDTH     (C_AW),
        .SELECT_WIDTH   (C_SW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wbm_adr      (wbm_adr),
        .wbm_dat_m    (wbm_dat_m),
        .wbm_dat_s    (wbm_dat_s),
        .wbm_sel      (wbm_sel),
        .wbm_we       (wbm_we),
        .wbm_cyc      (wbm_cyc),
        .wbm_stb      (wbm_stb),
        .wbm_ack      (wbm_ack),
        .wbm_err      (wbm_err),
        .wbm_stall    (wbm_stall),
        .wbs_adr      (wbs_adr),
        .wbs_dat_m    (wbs_dat_m),
        .wbs_dat_s    (wbs_dat_s),
        .wbs_sel      (wbs_sel),
        .wbs_we       (wbs_we),
        .wbs_cyc      (wbs_cyc),
        .wbs_stb      (wbs_stb),
        .wbs_ack      (wbs_ack),
        .wbs_err      (wbs_err),
        .wbs_stall    (wbs_stall),
        .clear_status (clear_status),
        .timeout_flag (timeout_flag),
        .timeout_addr (timeout_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each cycle: inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wbm_adr = '0; wbm_dat_m = '0; wbm_sel = '0; wbm_we = 1'b0;
        wbm_cyc = 1'b1; wbm_stb = 1'b0; wbs_dat_s = '0; wbs_ack = 1'b0;
        wbs_err = 1'b1; wbs_stall = 1'b0; clear_status = 1'b0;

        // Reset
        tick(); #1;
        chk("reset_err_forced", wbm_err, 0);
        chk("reset_cyc_passthru", wbs_cyc, 1);
        tick(); rst = 1'b0; wbm_cyc = 1'b0; wbs_err = 1'b0; #1;
        chk("reset_flag", timeout_flag, 0);
        chk("reset_addr", timeout_addr, 0);

        // Normal read, ack two cycles after stb
        tick(); wbm_cyc = 1; wbm_stb = 1; wbm_adr = 32'h1000_0010;
        wbm_dat_m = 32'h1122_3344; wbm_sel = 4'hF; #1;
        chk("rd_wbs_cyc", wbs_cyc, 1);
        chk("rd_wbs_stb", wbs_stb, 1);
        chk("rd_wbs_adr", wbs_adr, 32'h1000_0010);
        chk("rd_wbs_dat", wbs_dat_m, 32'h1122_3344);
        tick(); wbm_stb = 0; wbs_stall = 1; #1;
        chk("rd_stall_passthru", wbm_stall, 1);
        tick(); wbs_stall = 0; wbs_ack = 1; wbs_dat_s = 32'hCAFE_BABE; #1;
        chk("rd_ack", wbm_ack, 1);
        chk("rd_dat_s", wbm_dat_s, 32'hCAFE_BABE);
        chk("rd_no_err", wbm_err, 0);
        tick(); wbs_ack = 0; wbm_cyc = 0; #1;
        chk("rd_flag", timeout_flag, 0);

        // Stuck slave at 0x1000_0020
        tick(); wbm_cyc = 1; wbm_stb = 1; wbm_adr = 32'h1000_0020; #1;
        tick(); wbm_stb = 0; wbm_adr = 32'hDEAD_0000; #1;
        chk("stuck_c1_err", wbm_err, 0);
        for (int k = 2; k <= 8; k++) begin
            tick(); #1;
            chk("stuck_wait_err", wbm_err, 0);
            chk("stuck_wait_cyc", wbs_cyc, 1);
        end
        tick(); wbs_ack = 1; wbm_stb = 1; #1;   // cycle 9: ABORT, late ack
        chk("abort_err", wbm_err, 1);
        chk("abort_ack_dropped", wbm_ack, 0);
        chk("abort_stall", wbm_stall, 1);
        chk("abort_wbs_cyc", wbs_cyc, 0);
        chk("abort_wbs_stb", wbs_stb, 0);
        chk("abort_flag_not_yet", timeout_flag, 0);
        tick(); wbs_ack = 0; wbm_stb = 0; #1;   // cycle 10: DRAIN
        chk("drain_flag", timeout_flag, 1);
        chk("drain_addr", timeout_addr, 32'h1000_0020);
        chk("drain_err_once", wbm_err, 0);
        chk("drain_wbs_cyc", wbs_cyc, 0);
        chk("drain_stall", wbm_stall, 1);
        tick(); wbs_ack = 1; #1;               // cycle 11: late ack discarded
        chk("drain_late_ack", wbm_ack, 0);
        chk("drain_wbs_cyc2", wbs_cyc, 0);
        tick(); wbs_ack = 0; #1;               // cycle 12
        chk("drain_stall2", wbm_stall, 1);
        tick(); wbm_cyc = 0; #1;               // cycle 13: cyc dropped, still DRAIN
        chk("drain_stall3", wbm_stall, 1);
        tick(); wbm_cyc = 1; wbm_stb = 1; wbm_adr = 32'h1000_0050; #1;
        chk("resume_wbs_cyc", wbs_cyc, 1);
        chk("resume_wbs_stb", wbs_stb, 1);
        chk("resume_stall", wbm_stall, 0);
        tick(); wbm_stb = 0; wbs_ack = 1; #1;
        chk("resume_ack", wbm_ack, 1);
        tick(); wbm_cyc = 0; wbs_ack = 0; #1;

        // Clear status
        tick(); clear_status = 1; #1;
        tick(); clear_status = 0; #1;
        chk("clear_flag", timeout_flag, 0);
        chk("clear_addr_kept", timeout_addr, 32'h1000_0020);

        // Boundary: ack in cycle 8 is forwarded
        tick(); wbm_cyc = 1; wbm_stb = 1; wbm_adr = 32'h1000_0030; #1;
        tick(); wbm_stb = 0; #1;
        for (int k = 2; k <= 7; k++) begin
            tick(); #1;
        end
        tick(); wbs_ack = 1; #1;
        chk("bnd_ack", wbm_ack, 1);
        chk("bnd_no_err", wbm_err, 0);
        tick(); wbs_ack = 0; wbm_cyc = 0; #1;
        chk("bnd_no_err_c9", wbm_err, 0);
        chk("bnd_no_stall_c9", wbm_stall, 0);
        tick(); #1;
        chk("bnd_flag", timeout_flag, 0);
        chk("bnd_addr", timeout_addr, 32'h1000_0020);

        // Abort with coincident clear; stalled second request is not recorded
        tick(); wbm_cyc = 1; wbm_stb = 1; wbm_adr = 32'h1000_0040; #1;
        tick(); wbm_adr = 32'h1000_0044; wbs_stall = 1; #1;
        tick(); wbm_stb = 0; wbs_stall = 0; #1;
        for (int k = 3; k <= 8; k++) begin
            tick(); #1;
        end
        tick(); clear_status = 1; #1;
        chk("coinc_err", wbm_err, 1);
        tick(); clear_status = 0; #1;
        chk("coinc_flag", timeout_flag, 1);
        chk("coinc_addr", timeout_addr, 32'h1000_0040);
        chk("coinc_drain_cyc", wbs_cyc, 0);

        // Reset during DRAIN
        tick(); rst = 1; #1;
        tick(); rst = 0; #1;
        chk("rstd_flag", timeout_flag, 0);
        chk("rstd_addr", timeout_addr, 0);
        chk("rstd_wbs_cyc", wbs_cyc, 1);
        chk("rstd_stall", wbm_stall, 0);
        tick(); wbm_cyc = 0; #1;
        chk("rstd_wbs_cyc_low", wbs_cyc, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
